a25_mem_port_arbiter: RTL and testbench

Sequences the single shared memory bus between the a25_execute instruction-fetch port and its data port.
- Fixed data priority, with an anti-starvation counter for fetches.
- Registered bus-side outputs.
- Per-transfer timeout and error reporting.
- Produces the stall request that feeds the execute stage's memory-stall input.

---
 rtl/a25_arb_pkg.sv | 26 ++
 rtl/a25_mem_port_arbiter_if.sv | 54 +++++
 rtl/a25_arb_sat_counter.sv | 33 +++
 rtl/a25_mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_a25_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/a25_arb_pkg.sv
// Shared types and constants for the a25 memory-port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_src_t   : error source encoding reported on o_err_src
//   BE_W/BE_ALL : byte-enable width and the full-word enable used for fetches
//   cnt_w()     : counter width needed to hold 0..limit (never below 1 bit)
package a25_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    localparam int unsigned BE_W = 4;
    localparam logic [BE_W-1:0] BE_ALL = 4'hF;

    function automatic int unsigned cnt_w(input int unsigned limit);
        return (limit < 2) ? 1 : 32'($clog2(limit + 1));
    endfunction

endpackage

// File: rtl/a25_mem_port_arbiter_if.sv
// Signal bundle between the a25 fetch/data requesters, the arbiter and the bus.
//   slave  : arbiter view (requests and bus responses in, grants/acks/bus out)
//   master : requester/bus-model view (the mirror image)
interface a25_mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import a25_arb_pkg::*;

    // fetch port
    logic              i_ireq;
    logic [ADDR_W-1:0] i_iaddr;
    logic              o_iack;
    logic [DATA_W-1:0] o_irdata;
    // data port
    logic              i_dreq;
    logic [ADDR_W-1:0] i_daddr;
    logic              i_dwe;
    logic [BE_W-1:0]   i_dbe;
    logic [DATA_W-1:0] i_dwdata;
    logic              o_dack;
    logic [DATA_W-1:0] o_drdata;
    // shared bus
    logic              o_bus_cyc;
    logic [ADDR_W-1:0] o_bus_adr;
    logic              o_bus_we;
    logic [BE_W-1:0]   o_bus_sel;
    logic [DATA_W-1:0] o_bus_dat;
    logic              i_bus_ack;
    logic              i_bus_err;
    logic [DATA_W-1:0] i_bus_dat;
    // status
    logic              o_mem_stall;
    logic              o_err_valid;
    logic              o_err_src;
    logic              o_err_timeout;

    modport slave (
        input  i_ireq, i_iaddr, i_dreq, i_daddr, i_dwe, i_dbe, i_dwdata,
               i_bus_ack, i_bus_err, i_bus_dat,
        output o_iack, o_irdata, o_dack, o_drdata,
               o_bus_cyc, o_bus_adr, o_bus_we, o_bus_sel, o_bus_dat,
               o_mem_stall, o_err_valid, o_err_src, o_err_timeout
    );

    modport master (
        output i_ireq, i_iaddr, i_dreq, i_daddr, i_dwe, i_dbe, i_dwdata,
               i_bus_ack, i_bus_err, i_bus_dat,
        input  o_iack, o_irdata, o_dack, o_drdata,
               o_bus_cyc, o_bus_adr, o_bus_we, o_bus_sel, o_bus_dat,
               o_mem_stall, o_err_valid, o_err_src, o_err_timeout
    );

endinterface

// File: rtl/a25_arb_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count up by one (holds once LIMIT is reached)
//   clr        : return to zero, takes priority over inc
//   at_limit   : count equals LIMIT
module a25_arb_sat_counter
    import a25_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned WIDTH = cnt_w(LIMIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [WIDTH-1:0] cnt;

    assign at_limit = (cnt == WIDTH'(LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/a25_mem_port_arbiter.sv
// Arbitrates the shared memory bus between the a25 fetch and data ports.
// Data has fixed priority; a fetch is forced through after STARVE_LIMIT data
// grants. Each transfer ends on bus ack, bus error or a TIMEOUT-cycle limit,
// and is answered with a one-cycle ack pulse on the granted port.
//   clk, reset : clock, synchronous active-high reset
//   port       : fetch port, data port, shared bus and error/stall status
module a25_mem_port_arbiter
    import a25_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    a25_mem_port_arbiter_if.slave  port
);

    localparam int unsigned TMO_LIMIT = TIMEOUT - 1;

    arb_state_t        state;
    logic              ireq_eff;
    logic              dreq_eff;
    logic              turnaround;
    logic              in_gnt;
    logic              grant_d;
    logic              grant_i;
    logic              term;
    logic              bus_fault;
    logic [DATA_W-1:0] rdata_c;
    logic              starve_inc;
    logic              starve_clr;
    logic              starve_full;
    logic              tmo_full;

    // A request is not re-granted in the cycle its own ack pulse is out.
    assign ireq_eff = port.i_ireq & ~port.o_iack;
    assign dreq_eff = port.i_dreq & ~port.o_dack;

    // No grant while any ack pulse is out: a port being acked must not lose to
    // the other port just because its own request is masked. This also sets
    // the 3-cycle cadence per transfer with a single-cycle bus ack.
    assign turnaround = port.o_iack | port.o_dack;
    assign in_gnt     = (state != IDLE);

    assign grant_d = (state == IDLE) & ~turnaround & dreq_eff & (~ireq_eff | ~starve_full);
    assign grant_i = (state == IDLE) & ~turnaround & ~grant_d & ireq_eff;

    // Terminate on ack, error or the last allowed cycle; ack beats the timeout.
    assign term      = in_gnt & (port.i_bus_ack | port.i_bus_err | tmo_full);
    assign bus_fault = port.i_bus_err | ~port.i_bus_ack;
    assign rdata_c   = bus_fault ? DATA_W'(0) : port.i_bus_dat;

    assign starve_inc = grant_d & ireq_eff;
    assign starve_clr = grant_i | ((state == IDLE) & ~ireq_eff);

    assign port.o_mem_stall = port.i_dreq & ~port.o_dack;

    // Data grants taken while a fetch waits.
    a25_arb_sat_counter #(.LIMIT(STARVE_LIMIT)) u_starve_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (starve_full)
    );

    // Cycles spent in the current grant.
    a25_arb_sat_counter #(.LIMIT(TMO_LIMIT)) u_tmo_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (in_gnt),
        .clr      (term),
        .at_limit (tmo_full)
    );

    // FSM with registered bus, ack and error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            port.o_iack        <= 1'b0;
            port.o_irdata      <= '0;
            port.o_dack        <= 1'b0;
            port.o_drdata      <= '0;
            port.o_bus_cyc     <= 1'b0;
            port.o_bus_adr     <= '0;
            port.o_bus_we      <= 1'b0;
            port.o_bus_sel     <= '0;
            port.o_bus_dat     <= '0;
            port.o_err_valid   <= 1'b0;
            port.o_err_src     <= 1'b0;
            port.o_err_timeout <= 1'b0;
        end else begin
            port.o_iack      <= 1'b0;
            port.o_dack      <= 1'b0;
            port.o_err_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state          <= GNT_D;
                        port.o_bus_cyc <= 1'b1;
                        port.o_bus_adr <= ADDR_W'(port.i_daddr);
                        port.o_bus_we  <= port.i_dwe;
                        port.o_bus_sel <= port.i_dbe;
                        port.o_bus_dat <= port.i_dwdata;
                    end else if (grant_i) begin
                        state          <= GNT_I;
                        port.o_bus_cyc <= 1'b1;
                        port.o_bus_adr <= ADDR_W'(port.i_iaddr);
                        port.o_bus_we  <= 1'b0;
                        port.o_bus_sel <= BE_ALL;
                        port.o_bus_dat <= DATA_W'(0);
                    end
                end
                GNT_I, GNT_D: begin
                    if (term) begin
                        state          <= IDLE;
                        port.o_bus_cyc <= 1'b0;
                        if (state == GNT_D) begin
                            port.o_dack   <= 1'b1;
                            port.o_drdata <= rdata_c;
                        end else begin
                            port.o_iack   <= 1'b1;
                            port.o_irdata <= rdata_c;
                        end
                        if (bus_fault) begin
                            port.o_err_valid   <= 1'b1;
                            port.o_err_src     <= (state == GNT_D) ? SRC_D : SRC_I;
                            port.o_err_timeout <= ~port.i_bus_err;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    port.o_bus_cyc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a25_mem_port_arbiter.sv
// Self-checking bench for a25_mem_port_arbiter: a table of single transfers
// plus directed sequences for starvation ordering and mid-transfer reset.
module tb_a25_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    a25_mem_port_arbiter_if bif ();

    a25_mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .port  (bif)
    );

    always #5 clk = ~clk;

    // resp: 0 = ack, 1 = err, 2 = ack+err; ack_dly 255 = bus never answers
    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          ack_dly;
        int          resp;
        logic [31:0] rdata;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        bit          exp_errv;
        bit          exp_src;
        bit          exp_tmo;
    } vec_t;

    vec_t vecs [8];

    a_ireq_hold: assert property (@(posedge clk) disable iff (reset)
        $fell(bif.i_ireq) |-> bif.o_iack)
        else $error("fetch request withdrawn before its ack");
    a_dreq_hold: assert property (@(posedge clk) disable iff (reset)
        $fell(bif.i_dreq) |-> bif.o_dack)
        else $error("data request withdrawn before its ack");

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int   ncyc;
        int   t_ack;
        logic pulse;
        ncyc  = 0;
        t_ack = 0;
        if (v.is_data) begin
            bif.i_daddr  = v.addr;
            bif.i_dwe    = v.we;
            bif.i_dbe    = v.be;
            bif.i_dwdata = v.wdata;
            bif.i_dreq   = 1'b1;
        end else begin
            bif.i_iaddr = v.addr;
            bif.i_ireq  = 1'b1;
        end
        for (int t = 1; t <= 40 && t_ack == 0; t++) begin
            tick();
            bif.i_bus_ack = 1'b0;
            bif.i_bus_err = 1'b0;
            if (t == 1) begin
                chk($sformatf("v%0d_cyc_latency", idx), 32'(bif.o_bus_cyc), 32'd1);
                chk($sformatf("v%0d_adr", idx), bif.o_bus_adr, v.addr);
                chk($sformatf("v%0d_we", idx), 32'(bif.o_bus_we), v.is_data ? 32'(v.we) : 32'd0);
                chk($sformatf("v%0d_sel", idx), 32'(bif.o_bus_sel), v.is_data ? 32'(v.be) : 32'hF);
                if (v.is_data) chk($sformatf("v%0d_dat", idx), bif.o_bus_dat, v.wdata);
                chk($sformatf("v%0d_stall", idx), 32'(bif.o_mem_stall), 32'(v.is_data));
            end
            pulse = v.is_data ? bif.o_dack : bif.o_iack;
            if (bif.o_bus_cyc) begin
                if (ncyc == v.ack_dly) begin
                    bif.i_bus_ack = (v.resp != 1);
                    bif.i_bus_err = (v.resp != 0);
                    bif.i_bus_dat = v.rdata;
                end
                ncyc++;
            end else if (pulse) begin
                t_ack = t;
                chk($sformatf("v%0d_ack_cycle", idx), 32'(t), 32'(v.exp_cyc + 1));
                chk($sformatf("v%0d_cyc_len", idx), 32'(ncyc), 32'(v.exp_cyc));
                chk($sformatf("v%0d_rdata", idx), v.is_data ? bif.o_drdata : bif.o_irdata, v.exp_rdata);
                chk($sformatf("v%0d_err_valid", idx), 32'(bif.o_err_valid), 32'(v.exp_errv));
                chk($sformatf("v%0d_err_src", idx), 32'(bif.o_err_src), 32'(v.exp_src));
                chk($sformatf("v%0d_err_tmo", idx), 32'(bif.o_err_timeout), 32'(v.exp_tmo));
                chk($sformatf("v%0d_stall_ack", idx), 32'(bif.o_mem_stall), 32'd0);
                bif.i_ireq = 1'b0;
                bif.i_dreq = 1'b0;
            end
        end
        if (t_ack == 0) begin
            chk($sformatf("v%0d_ack_seen", idx), 32'd0, 32'd1);
            bif.i_ireq = 1'b0;
            bif.i_dreq = 1'b0;
        end
        tick();
        chk($sformatf("v%0d_ack_1cyc", idx), 32'(bif.o_iack | bif.o_dack), 32'd0);
        chk($sformatf("v%0d_errv_1cyc", idx), 32'(bif.o_err_valid), 32'd0);
    endtask

    initial begin
        bit   grants_d [16];
        bit   exp_d [11];
        int   ng;
        bit   done;
        bit   expect_dack;
        bit   next_dack;

        vecs[0] = '{1'b0, 32'h0000_0100, 1'b0, 4'h0, 32'h0,      2,   0, 32'hDEAD_BEEF, 3,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h2000_0004, 1'b1, 4'h3, 32'h1234,   0,   0, 32'h0,         1,  32'h0,         1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h3000_0010, 1'b0, 4'hF, 32'h0,      1,   0, 32'hA5A5_5A5A, 2,  32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0040, 1'b0, 4'hC, 32'h0,      255, 0, 32'h1111_1111, 15, 32'h0,         1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0044, 1'b0, 4'hF, 32'h0,      0,   0, 32'h2222_3333, 1,  32'h2222_3333, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0104, 1'b0, 4'h0, 32'h0,      0,   2, 32'h4444_5555, 1,  32'h0,         1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0048, 1'b1, 4'h8, 32'h77,     1,   1, 32'h6666_7777, 2,  32'h0,         1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0108, 1'b0, 4'h0, 32'h0,      14,  0, 32'h89AB_CDEF, 15, 32'h89AB_CDEF, 1'b0, 1'b1, 1'b0};
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        reset         = 1'b1;
        bif.i_ireq    = 1'b0;
        bif.i_iaddr   = '0;
        bif.i_dreq    = 1'b0;
        bif.i_daddr   = '0;
        bif.i_dwe     = 1'b0;
        bif.i_dbe     = '0;
        bif.i_dwdata  = '0;
        bif.i_bus_ack = 1'b0;
        bif.i_bus_err = 1'b0;
        bif.i_bus_dat = '0;

        // reset state
        tick();
        tick();
        chk("rst_cyc", 32'(bif.o_bus_cyc), 32'd0);
        chk("rst_acks", 32'({bif.o_iack, bif.o_dack}), 32'd0);
        chk("rst_adr", bif.o_bus_adr, 32'd0);
        chk("rst_sel", 32'(bif.o_bus_sel), 32'd0);
        chk("rst_err", 32'({bif.o_err_valid, bif.o_err_src, bif.o_err_timeout}), 32'd0);
        chk("rst_stall", 32'(bif.o_mem_stall), 32'd0);
        reset = 1'b0;
        tick();

        // single transfers from the table
        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // both ports requesting continuously, single-cycle bus ack
        bif.i_iaddr = 32'h100;
        bif.i_daddr = 32'h200;
        bif.i_dwe   = 1'b0;
        bif.i_dbe   = 4'hF;
        bif.i_ireq  = 1'b1;
        bif.i_dreq  = 1'b1;
        ng          = 0;
        done        = 1'b0;
        expect_dack = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            tick();
            bif.i_bus_ack = 1'b0;
            next_dack     = 1'b0;
            chk($sformatf("starve_c%0d_dack", c), 32'(bif.o_dack), 32'(expect_dack));
            chk($sformatf("starve_c%0d_stall", c), 32'(bif.o_mem_stall), 32'(!expect_dack));
            if (bif.o_bus_cyc && ng < 16) begin
                grants_d[ng]  = (bif.o_bus_adr == 32'h200);
                next_dack     = grants_d[ng];
                ng++;
                bif.i_bus_ack = 1'b1;
                bif.i_bus_dat = 32'(ng);
            end
            if (bif.o_iack && ng == 10) bif.i_ireq = 1'b0;
            if (bif.o_dack && ng == 11) begin
                bif.i_dreq = 1'b0;
                done       = 1'b1;
            end
            expect_dack = next_dack;
        end
        bif.i_ireq    = 1'b0;
        bif.i_dreq    = 1'b0;
        bif.i_bus_ack = 1'b0;
        chk("starve_grant_count", 32'(ng), 32'd11);
        for (int k = 0; k < 11; k++) begin
            if (k < ng) chk($sformatf("starve_grant%0d_is_data", k), 32'(grants_d[k]), 32'(exp_d[k]));
        end

        // reset one cycle into a data grant, request kept high
        tick();
        tick();
        bif.i_daddr = 32'h4000;
        bif.i_dwe   = 1'b0;
        bif.i_dbe   = 4'hF;
        bif.i_dreq  = 1'b1;
        tick();
        chk("rstmid_granted", 32'(bif.o_bus_cyc), 32'd1);
        reset = 1'b1;
        tick();
        chk("rstmid_cyc_drop", 32'(bif.o_bus_cyc), 32'd0);
        chk("rstmid_no_dack", 32'(bif.o_dack), 32'd0);
        chk("rstmid_err_clear", 32'({bif.o_err_src, bif.o_err_timeout}), 32'd0);
        reset = 1'b0;
        tick();
        chk("rstmid_regrant_cyc", 32'(bif.o_bus_cyc), 32'd1);
        chk("rstmid_regrant_adr", bif.o_bus_adr, 32'h4000);
        chk("rstmid_regrant_no_dack", 32'(bif.o_dack), 32'd0);
        bif.i_bus_ack = 1'b1;
        bif.i_bus_dat = 32'h0BAD_F00D;
        tick();
        bif.i_bus_ack = 1'b0;
        chk("rstmid_dack", 32'(bif.o_dack), 32'd1);
        chk("rstmid_drdata", bif.o_drdata, 32'h0BAD_F00D);
        chk("rstmid_no_err", 32'(bif.o_err_valid), 32'd0);
        bif.i_dreq = 1'b0;
        tick();
        chk("rstmid_dack_1cyc", 32'(bif.o_dack), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
